down_timer: RTL and testbench

- Loadable down-counting timer with prescaler, one-shot/auto-reload modes and a terminal-count pulse.
- Counterpart to the team's loadable up-counter: it is loaded with a value and consumes it down to zero, instead of accumulating from zero.
- Used as a timeout/interval generator next to the counter blocks. Single clock domain.

---
 rtl/down_timer.sv | 146 ++++++++++++++
 tb/tb_down_timer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with prescaler, one-shot/auto-reload modes and a
// registered terminal-count pulse. Defining DOWN_TIMER_IRQ_EN adds a sticky irq with irq_clr.
module down_timer #(
   parameter int WIDTH     = 8,
   parameter int PRE_WIDTH = 4
) (
`ifdef DOWN_TIMER_IRQ_EN
   input  logic                 i_irq_clr,
   output logic                 o_irq,
`endif
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_wen,
   input  logic [WIDTH-1:0]     i_dat,
   input  logic                 i_start,
   input  logic                 i_stop,
   input  logic                 i_cen,
   input  logic [PRE_WIDTH-1:0] i_pre,
   input  logic                 i_auto,
   output logic [WIDTH-1:0]     o_cnt,
   output logic                 o_busy,
   output logic                 o_expired
);

   // state | meaning
   // IDLE  | stopped; cnt holds its last value
   // RUN   | counting down one step per prescaler tick
   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WIDTH-1:0]     r_ld;
   logic [WIDTH-1:0]     r_cnt;
   logic [WIDTH-1:0]     w_cnt_nxt;
   logic [WIDTH-1:0]     w_load_val;
   logic [PRE_WIDTH-1:0] r_psc;
   logic [PRE_WIDTH-1:0] w_psc_nxt;
   logic                 r_expired;
   logic                 w_expired_nxt;
   logic                 w_tick;

   // A write in the same cycle as start takes effect immediately for the start.
   assign w_load_val = i_wen ? i_dat : r_ld;
   // >= rather than == so lowering pre mid-count never skips a tick.
   assign w_tick     = (r_state == S_RUN) && i_cen && (r_psc >= i_pre);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_ld      <= '0;
         r_cnt     <= '0;
         r_psc     <= '0;
         r_expired <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_psc     <= w_psc_nxt;
         r_expired <= w_expired_nxt;
         if (i_wen) begin
            r_ld <= i_dat;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_psc_nxt     = r_psc;
      w_expired_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_stop) begin
               w_psc_nxt = '0;
            end else if (i_start) begin
               w_psc_nxt = '0;
               w_cnt_nxt = w_load_val;
               if (w_load_val != '0) begin
                  w_state_nxt = S_RUN;
               end else begin
                  w_expired_nxt = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (i_stop) begin
               w_state_nxt = S_IDLE;
               w_psc_nxt   = '0;
            end else if (i_start) begin
               w_psc_nxt = '0;
               w_cnt_nxt = w_load_val;
               if (w_load_val == '0) begin
                  w_state_nxt   = S_IDLE;
                  w_expired_nxt = 1'b1;
               end
            end else if (w_tick) begin
               w_psc_nxt = '0;
               if (r_cnt > WIDTH'(1)) begin
                  w_cnt_nxt = r_cnt - WIDTH'(1);
               end else if (r_cnt == WIDTH'(1)) begin
                  w_expired_nxt = 1'b1;
                  if (i_auto && (r_ld != '0)) begin
                     w_cnt_nxt = r_ld;
                  end else begin
                     w_cnt_nxt   = '0;
                     w_state_nxt = S_IDLE;
                  end
               end
            end else if (i_cen) begin
               w_psc_nxt = r_psc + PRE_WIDTH'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign o_cnt     = r_cnt;
   assign o_busy    = (r_state == S_RUN);
   assign o_expired = r_expired;

`ifdef DOWN_TIMER_IRQ_EN
   logic r_irq;
   logic w_irq_set;

   // Set is seen on the terminal edge and through the following pulse cycle, so a clear
   // overlapping either one loses to the set.
   assign w_irq_set = w_expired_nxt | r_expired;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_irq <= 1'b0;
      end else if (w_irq_set) begin
         r_irq <= 1'b1;
      end else if (i_irq_clr) begin
         r_irq <= 1'b0;
      end
   end

   assign o_irq = r_irq;
`endif

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus randomized stimulus against a
// behavioural model of the timer rules.
`timescale 1ns/1ps
module tb_down_timer;

   logic       clk = 1'b0;
   logic       rst, wen, start, stop, cen, auto;
   logic [7:0] dat;
   logic [3:0] pre;
   logic [7:0] cnt;
   logic       busy, expired;
`ifdef DOWN_TIMER_IRQ_EN
   logic       irq_clr, irq;
`endif

   int checks = 0;
   int errors = 0;

   int m_ld, m_cnt, m_psc;
   bit m_run, m_exp, m_irq;

   down_timer #(.WIDTH(8), .PRE_WIDTH(4)) dut (
`ifdef DOWN_TIMER_IRQ_EN
      .i_irq_clr(irq_clr),
      .o_irq    (irq),
`endif
      .i_clk    (clk),
      .i_rst    (rst),
      .i_wen    (wen),
      .i_dat    (dat),
      .i_start  (start),
      .i_stop   (stop),
      .i_cen    (cen),
      .i_pre    (pre),
      .i_auto   (auto),
      .o_cnt    (cnt),
      .o_busy   (busy),
      .o_expired(expired)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_ld = 0; m_cnt = 0; m_psc = 0; m_run = 0; m_exp = 0; m_irq = 0;
   endfunction

   // One clock edge of the timer rules: stop beats start beats tick.
   function automatic void model_edge();
      int lv;
      bit exp_n;
      bit clr;
      lv    = wen ? int'(dat) : m_ld;
      exp_n = 0;
      if (stop) begin
         m_run = 0;
         m_psc = 0;
      end else if (start) begin
         m_psc = 0;
         m_cnt = lv;
         m_run = (lv != 0);
         exp_n = (lv == 0);
      end else if (m_run && cen) begin
         if (m_psc >= int'(pre)) begin
            m_psc = 0;
            if (m_cnt >= 2) begin
               m_cnt = m_cnt - 1;
            end else begin
               exp_n = 1;
               if (auto && m_ld != 0) m_cnt = m_ld;
               else begin m_cnt = 0; m_run = 0; end
            end
         end else begin
            m_psc = m_psc + 1;
         end
      end
`ifdef DOWN_TIMER_IRQ_EN
      clr = irq_clr;
`else
      clr = 0;
`endif
      m_irq = exp_n | m_exp | (m_irq & ~clr);
      m_exp = exp_n;
      if (wen) m_ld = int'(dat);
   endfunction

   task automatic tick_edge();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({cnt, busy, expired} !== 10'b0) begin
         errors++;
         $display("FAIL reset_init got cnt=%0d busy=%0b exp=%0b want 0 0 0", cnt, busy, expired);
      end
      @(negedge clk);
      wen = 1; dat = 8'd5; start = 1; pre = 4'd15; cen = 1;
      tick_edge();
      wen = 0; start = 0;
      tick_edge();
      tick_edge();
      checks++;
      if (cnt !== 8'd5 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_prerun got cnt=%0d busy=%0b want 5 1", cnt, busy);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({cnt, busy, expired} !== 10'b0) begin
         errors++;
         $display("FAIL reset_async got cnt=%0d busy=%0b exp=%0b want 0 0 0", cnt, busy, expired);
      end
      model_reset();
      #1 rst = 1'b0;
      tick_edge();
      start = 1;
      tick_edge();
      start = 0;
      checks++;
      if ({cnt, busy, expired} !== {8'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_ld_zero got cnt=%0d busy=%0b exp=%0b want 0 0 1", cnt, busy, expired);
      end
      tick_edge();
   endtask

   task automatic test_oneshot();
      int ec[4] = '{2, 1, 0, 0};
      bit eb[4] = '{1, 1, 0, 0};
      bit ee[4] = '{0, 0, 1, 0};
      wen = 1; dat = 8'd3; pre = 4'd0; auto = 0; cen = 1; start = 1;
      tick_edge();
      wen = 0; start = 0;
      checks++;
      if ({cnt, busy, expired} !== {8'd3, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL oneshot_load got cnt=%0d busy=%0b exp=%0b want 3 1 0", cnt, busy, expired);
      end
      for (int i = 0; i < 4; i++) begin
         tick_edge();
         checks++;
         if (cnt !== 8'(ec[i]) || busy !== eb[i] || expired !== ee[i]) begin
            errors++;
            $display("FAIL oneshot_step%0d got cnt=%0d busy=%0b exp=%0b want %0d %0b %0b",
                     i, cnt, busy, expired, ec[i], eb[i], ee[i]);
         end
      end
   endtask

   task automatic test_autoreload();
      int pulses = 0;
      int want_cnt;
      wen = 1; dat = 8'd4;
      tick_edge();
      wen = 0; pre = 4'd2; auto = 1; cen = 1; start = 1;
      tick_edge();
      start = 0;
      for (int k = 1; k <= 30; k++) begin
         tick_edge();
         want_cnt = 4 - ((k / 3) % 4);
         if (expired) pulses++;
         checks++;
         if (cnt !== 8'(want_cnt) || expired !== (k % 12 == 0) || busy !== 1'b1) begin
            errors++;
            $display("FAIL autoreload_k%0d got cnt=%0d exp=%0b busy=%0b want %0d %0b 1",
                     k, cnt, expired, busy, want_cnt, (k % 12 == 0));
         end
      end
      checks++;
      if (pulses != 2) begin
         errors++;
         $display("FAIL autoreload_pulses got %0d want 2", pulses);
      end
      stop = 1;
      tick_edge();
      stop = 0;
      checks++;
      if ({cnt, busy, expired} !== {8'd2, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL autoreload_stop got cnt=%0d busy=%0b exp=%0b want 2 0 0", cnt, busy, expired);
      end
   endtask

   task automatic test_zero_load();
      wen = 1; dat = 8'd0; start = 1; cen = 1;
      tick_edge();
      wen = 0; start = 0;
      checks++;
      if ({cnt, busy, expired} !== {8'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL zero_load got cnt=%0d busy=%0b exp=%0b want 0 0 1", cnt, busy, expired);
      end
      tick_edge();
      checks++;
      if ({cnt, busy, expired} !== {8'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL zero_load_after got cnt=%0d busy=%0b exp=%0b want 0 0 0", cnt, busy, expired);
      end
   endtask

   task automatic test_freeze_stop();
      wen = 1; dat = 8'd6; start = 1; cen = 1; pre = 4'd0; auto = 0;
      tick_edge();
      wen = 0; start = 0; cen = 0;
      for (int i = 0; i < 5; i++) begin
         tick_edge();
         checks++;
         if ({cnt, busy, expired} !== {8'd6, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL freeze_c%0d got cnt=%0d busy=%0b exp=%0b want 6 1 0", i, cnt, busy, expired);
         end
      end
      stop = 1;
      tick_edge();
      stop = 0; cen = 1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({cnt, busy, expired} !== {8'd6, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stop_hold%0d got cnt=%0d busy=%0b exp=%0b want 6 0 0", i, cnt, busy, expired);
         end
         tick_edge();
      end
      dat = 8'd9; start = 1;
      tick_edge();
      start = 0;
      checks++;
      if ({cnt, busy} !== {8'd6, 1'b1}) begin
         errors++;
         $display("FAIL restart_ld got cnt=%0d busy=%0b want 6 1", cnt, busy);
      end
      stop = 1;
      tick_edge();
      stop = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         wen   = ($urandom % 8 == 0);
         dat   = 8'($urandom % 6);
         start = ($urandom % 10 == 0);
         stop  = ($urandom % 30 == 0);
         cen   = ($urandom % 4 != 0);
         if ($urandom % 16 == 0) pre = ($urandom % 8 == 0) ? 4'd15 : 4'($urandom % 4);
         if ($urandom % 20 == 0) auto = 1'($urandom % 2);
`ifdef DOWN_TIMER_IRQ_EN
         irq_clr = ($urandom % 6 == 0);
`endif
         tick_edge();
         checks++;
         if (cnt !== 8'(m_cnt) || busy !== m_run || expired !== m_exp) begin
            errors++;
            $display("FAIL random_c%0d got cnt=%0d busy=%0b exp=%0b want %0d %0b %0b",
                     i, cnt, busy, expired, m_cnt, m_run, m_exp);
         end
`ifdef DOWN_TIMER_IRQ_EN
         checks++;
         if (irq !== m_irq) begin
            errors++;
            $display("FAIL random_irq_c%0d got %0b want %0b", i, irq, m_irq);
         end
`endif
      end
      wen = 0; start = 0; stop = 1;
`ifdef DOWN_TIMER_IRQ_EN
      irq_clr = 0;
`endif
      tick_edge();
      stop = 0;
   endtask

`ifdef DOWN_TIMER_IRQ_EN
   task automatic test_irq();
      int n;
      irq_clr = 1;
      tick_edge();
      irq_clr = 0;
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_preclear got %0b want 0", irq);
      end
      wen = 1; dat = 8'd2; pre = 4'd0; auto = 1; cen = 1; start = 1;
      tick_edge();
      wen = 0; start = 0;
      n = 0;
      while (!expired && n < 10) begin tick_edge(); n++; end
      checks++;
      if (expired !== 1'b1 || irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_rise got exp=%0b irq=%0b want 1 1", expired, irq);
      end
      tick_edge();
      checks++;
      if (expired !== 1'b0 || irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_hold got exp=%0b irq=%0b want 0 1", expired, irq);
      end
      n = 0;
      while (!expired && n < 10) begin tick_edge(); n++; end
      irq_clr = 1;
      tick_edge();
      irq_clr = 0;
      checks++;
      if (irq !== 1'b1 || irq !== m_irq) begin
         errors++;
         $display("FAIL irq_setwins got %0b want 1", irq);
      end
      stop = 1;
      tick_edge();
      stop = 0;
      irq_clr = 1;
      tick_edge();
      irq_clr = 0;
      checks++;
      if (irq !== 1'b0 || irq !== m_irq) begin
         errors++;
         $display("FAIL irq_clear got %0b want 0", irq);
      end
   endtask
`endif

   initial begin
      rst = 1; wen = 0; dat = '0; start = 0; stop = 0; cen = 0; pre = '0; auto = 0;
`ifdef DOWN_TIMER_IRQ_EN
      irq_clr = 0;
`endif
      model_reset();
      test_reset();
      test_oneshot();
      test_autoreload();
      test_zero_load();
      test_freeze_stop();
      test_random();
`ifdef DOWN_TIMER_IRQ_EN
      test_irq();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
